l1d_write_buffer: RTL and testbench
===================================

Name: l1d_write_buffer

Overview:
- Posted-write buffer between the L1 data cache write-through port and the AXI M1 write channel.
- Accepts single-word stores from the cache in one cycle, queues up to DEPTH entries and merges same-word stores.
- Drains entries as single-beat AXI writes when the CPU wrapper grants the bus.
- Flags read hazards so the wrapper holds an M1 read while a matching write is still pending.

Parameters:
DEPTH, 4, number of buffer entries (power of 2, at least 2)
AXI_ID, 4'd0, constant value driven on AWID

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
wr_valid  input  1  cache store request
wr_ready  output  1  buffer can accept or merge this cycle
wr_addr  input  32  store byte address; bits [1:0] ignored
wr_data  input  32  store data, byte-lane aligned
wr_strb  input  4  byte enables, active-high
drain_en  input  1  wrapper grants M1 write channel; sampled only in IDLE
rd_addr  input  32  address of pending M1 read
rd_hazard  output  1  rd_addr word matches any occupied entry
empty  output  1  no occupied entries and FSM in IDLE
full  output  1  count == DEPTH
bresp_err  output  1  sticky: some BRESP != OKAY
AWID  output  4  = AXI_ID
AWADDR  output  32  head word address, {addr[31:2],2'b00}
AWLEN  output  4  constant 0
AWSIZE  output  3  constant 3'b010
AWBURST  output  2  constant 2'b01 (INCR)
AWVALID  output  1  address valid
AWREADY  input  1  address accepted
WDATA  output  32  head data
WSTRB  output  4  head strobes
WLAST  output  1  constant 1
WVALID  output  1  data valid
WREADY  input  1  data accepted
BID  input  4  response ID, ignored
BRESP  input  2  write response
BVALID  input  1  response valid
BREADY  output  1  response ready

Behaviour:
- Reset (async, rst=1): pointers and count = 0; state IDLE; aw_done/w_done = 0; bresp_err = 0. Outputs: AWVALID, WVALID, BREADY = 0; empty = 1; full = 0; wr_ready = 1. Reset mid-transaction abandons the transaction; the system reset covers the AXI peer.
- Storage: circular FIFO of {addr[31:2], data, strb}. Pointers have log2(DEPTH) bits and wrap naturally. count has log2(DEPTH)+1 bits.
- Merge: when wr_valid, the tail entry (newest) is occupied, its word address equals wr_addr[31:2], and the tail is not the in-flight head (not (count==1 && state!=IDLE)):
  - For each byte lane i with wr_strb[i]=1, overwrite tail data byte i.
  - OR wr_strb into the tail strb.
  - No push; merge is allowed even when full.
- Push: wr_valid && !merge && !full writes entry at wr_ptr; wr_ptr+1; count+1.
- wr_ready = !full || merge_hit (combinational). A push or merge takes effect at the clock edge when wr_valid && wr_ready.
- wr_strb == 0 is accepted and dropped (no push, no merge).
- FSM:
  - IDLE: if count != 0 && drain_en, go to SEND.
  - SEND: AWVALID = !aw_done; WVALID = !w_done. Set aw_done on AWVALID&&AWREADY and w_done on WVALID&&WREADY; both may complete in the same cycle. Once both are done (including the completing cycle), go to RESP and clear both flags.
  - RESP: BREADY = 1. On BVALID, pop the head (rd_ptr+1, count-1); if BRESP != 2'b00, set bresp_err; go to IDLE.
- AW/W payload is the head entry and is stable from entering SEND to leaving RESP.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- full blocks new pushes but not merges. A pop frees a slot for the next cycle, not the current one.
- rd_hazard: combinational compare of rd_addr[31:2] against every occupied entry, including the in-flight head.
- empty = (count == 0) && state == IDLE. The wrapper uses it as the store-drain / fence condition.
- bresp_err is cleared only by rst.
- Minimum drain latency: IDLE→SEND 1 cycle; SEND→RESP 1 cycle when AWREADY and WREADY are both high; pop on the first BVALID cycle. Best case 3 cycles per entry.

Test Plan:
1. Reset, then single push (addr 0x0001_0008, data 0xDEADBEEF, strb 4'hF) with drain_en=1, AWREADY=WREADY=1, BVALID the next cycle → AWADDR=0x0001_0008, WDATA=0xDEADBEEF, WSTRB=4'hF; pop on BVALID; empty=1 three cycles after the push.
2. drain_en=0, four pushes to distinct words → full=1 and wr_ready=0 on the 5th distinct write; rd_addr=the 3rd address gives rd_hazard=1; rd_addr=an unrelated address gives 0.
3. Push 0x1000 data 0x11223344 strb 4'h1, then 0x1002 data 0xAABBCCDD strb 4'h4 with drain_en=0 → count stays 1; drained WSTRB=4'h5, WDATA byte0=0x44, byte2=0xBB.
4. AWREADY held high, WREADY delayed 3 cycles → AWVALID high exactly one cycle; WVALID held high until WREADY; BREADY asserted only after both handshakes.
5. BRESP=2'b10 on the first drain → bresp_err=1 and stays 1; entry still popped; the next entry drains normally.
6. Full buffer with a push while the head's BVALID arrives → count stays at DEPTH-1 after the pop; a push the following cycle is accepted. rst asserted in SEND → AWVALID=WVALID=0 immediately and empty=1.

Source files
------------

// File: rtl/l1d_write_buffer.sv
// Posted-write buffer between the L1D write-through port and the AXI M1 write channel.
// Queues single-word stores, merges same-word stores into the tail, drains one beat at a time.
module l1d_write_buffer #(
   parameter int unsigned DEPTH  = 4,
   parameter logic [3:0]  AXI_ID = 4'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_strb,
   input  logic        drain_en,
   input  logic [31:0] rd_addr,
   output logic        rd_hazard,
   output logic        empty,
   output logic        full,
   output logic        bresp_err,
   output logic [3:0]  AWID,
   output logic [31:0] AWADDR,
   output logic [3:0]  AWLEN,
   output logic [2:0]  AWSIZE,
   output logic [1:0]  AWBURST,
   output logic        AWVALID,
   input  logic        AWREADY,
   output logic [31:0] WDATA,
   output logic [3:0]  WSTRB,
   output logic        WLAST,
   output logic        WVALID,
   input  logic        WREADY,
   input  logic [3:0]  BID,
   input  logic [1:0]  BRESP,
   input  logic        BVALID,
   output logic        BREADY
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

   state_t        state;
   logic [29:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [3:0]    strb_q [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, tail_ptr, off;
   logic [AW:0]   count;
   logic          merge_hit, push, pop, aw_hs, w_hs;
   logic          aw_done, w_done;
   logic          awvalid_r, wvalid_r, bready_r, bresp_err_r;
   logic          unused_bits;

   assign tail_ptr = wr_ptr - AW'(1);

   // The tail may not be merged into once it is the beat already on the bus.
   assign merge_hit = wr_valid && (count != '0) && (addr_q[tail_ptr] == wr_addr[31:2])
                      && !((count == (AW+1)'(1)) && (state != IDLE));
   assign full      = (count == DEPTH_C);
   assign wr_ready  = !full || merge_hit;
   assign push      = wr_valid && !merge_hit && !full && (wr_strb != '0);
   assign pop       = (state == RESP) && BVALID;
   assign aw_hs     = awvalid_r && AWREADY;
   assign w_hs      = wvalid_r && WREADY;

   assign empty     = (count == '0) && (state == IDLE);
   assign bresp_err = bresp_err_r;

   assign AWID    = AXI_ID;
   assign AWADDR  = {addr_q[rd_ptr], 2'b00};
   assign AWLEN   = 4'd0;
   assign AWSIZE  = 3'b010;
   assign AWBURST = 2'b01;
   assign AWVALID = awvalid_r;
   assign WDATA   = data_q[rd_ptr];
   assign WSTRB   = strb_q[rd_ptr];
   assign WLAST   = 1'b1;
   assign WVALID  = wvalid_r;
   assign BREADY  = bready_r;

   assign unused_bits = ^{BID, wr_addr[1:0], rd_addr[1:0]};

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= wr_addr[31:2];
         data_q[wr_ptr] <= wr_data;
         strb_q[wr_ptr] <= wr_strb;
      end else if (merge_hit) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (wr_strb[i]) data_q[tail_ptr][i*8 +: 8] <= wr_data[i*8 +: 8];
         end
         strb_q[tail_ptr] <= strb_q[tail_ptr] | wr_strb;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         bresp_err_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ((count != '0) && drain_en) begin
                  state     <= SEND;
                  awvalid_r <= 1'b1;
                  wvalid_r  <= 1'b1;
               end
            end
            SEND: begin
               if (aw_hs) begin
                  aw_done   <= 1'b1;
                  awvalid_r <= 1'b0;
               end
               if (w_hs) begin
                  w_done   <= 1'b1;
                  wvalid_r <= 1'b0;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  state    <= RESP;
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
                  bready_r <= 1'b1;
               end
            end
            RESP: begin
               if (BVALID) begin
                  bready_r <= 1'b0;
                  if (BRESP != 2'b00) bresp_err_r <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Occupancy is judged by distance from the head, so the in-flight head counts too.
   always_comb begin
      rd_hazard = 1'b0;
      off       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off = AW'(i) - rd_ptr;
         if (({1'b0, off} < count) && (addr_q[i] == rd_addr[31:2])) rd_hazard = 1'b1;
      end
   end

endmodule

// File: tb/tb_l1d_write_buffer.sv
// Directed bench for l1d_write_buffer: push/drain, full, merge, split handshakes, error response, reset.
module tb_l1d_write_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
   logic        drain_en;
   logic [31:0] rd_addr;
   logic        rd_hazard, empty, full, bresp_err;
   logic [3:0]  AWID, AWLEN, WSTRB, BID;
   logic [31:0] AWADDR, WDATA;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST, BRESP;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

   int n_checks = 0;
   int n_fail   = 0;

   l1d_write_buffer #(.DEPTH(4), .AXI_ID(4'd0)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_strb(wr_strb), .drain_en(drain_en), .rd_addr(rd_addr),
      .rd_hazard(rd_hazard), .empty(empty), .full(full), .bresp_err(bresp_err),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
      .WVALID(WVALID), .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
      .BREADY(BREADY)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; drain_en = 1'b0;
      rd_addr = 32'h0000_9000; AWREADY = 1'b1; WREADY = 1'b1; BID = '0; BRESP = 2'b00; BVALID = 1'b0;
      tick(); tick();
      n_checks++; if (AWVALID !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid got %b exp 0", AWVALID); end
      n_checks++; if (WVALID !== 1'b0) begin n_fail++; $display("FAIL rst_wvalid got %b exp 0", WVALID); end
      n_checks++; if (BREADY !== 1'b0) begin n_fail++; $display("FAIL rst_bready got %b exp 0", BREADY); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b exp 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b exp 0", full); end
      n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready got %b exp 1", wr_ready); end
      n_checks++; if (bresp_err !== 1'b0) begin n_fail++; $display("FAIL rst_bresp_err got %b exp 0", bresp_err); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_push();
      drain_en = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
      push(32'h0001_0008, 32'hDEADBEEF, 4'hF);
      tick();
      n_checks++; if (AWVALID !== 1'b1) begin n_fail++; $display("FAIL t1_awvalid got %b exp 1", AWVALID); end
      n_checks++; if (AWADDR !== 32'h0001_0008) begin n_fail++; $display("FAIL t1_awaddr got %h exp 00010008", AWADDR); end
      n_checks++; if (WDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_wdata got %h exp deadbeef", WDATA); end
      n_checks++; if (WSTRB !== 4'hF) begin n_fail++; $display("FAIL t1_wstrb got %h exp f", WSTRB); end
      n_checks++; if ({AWID, AWLEN, AWSIZE, AWBURST, WLAST} !== {4'd0, 4'd0, 3'b010, 2'b01, 1'b1})
         begin n_fail++; $display("FAIL t1_aw_consts got %h/%h/%h/%h/%b", AWID, AWLEN, AWSIZE, AWBURST, WLAST); end
      BVALID = 1'b1;
      tick();
      n_checks++; if (BREADY !== 1'b1) begin n_fail++; $display("FAIL t1_bready got %b exp 1", BREADY); end
      tick();
      BVALID = 1'b0;
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL t1_empty got %b exp 1", empty); end
      drain_en = 1'b0;
   endtask

   task automatic test_full_hazard();
      push(32'h0000_0100, 32'h1, 4'hF);
      push(32'h0000_0200, 32'h2, 4'hF);
      push(32'h0000_0300, 32'h3, 4'hF);
      push(32'h0000_0400, 32'h4, 4'hF);
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL t2_full got %b exp 1", full); end
      wr_valid = 1'b1; wr_addr = 32'h0000_0500; wr_data = 32'h5; wr_strb = 4'hF; #1;
      n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL t2_wr_ready_full got %b exp 0", wr_ready); end
      wr_addr = 32'h0000_0401; #1;
      n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL t2_merge_when_full got %b exp 1", wr_ready); end
      wr_valid = 1'b0;
      rd_addr = 32'h0000_0302; #1;
      n_checks++; if (rd_hazard !== 1'b1) begin n_fail++; $display("FAIL t2_hazard_hit got %b exp 1", rd_hazard); end
      rd_addr = 32'h0000_9000; #1;
      n_checks++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL t2_hazard_miss got %b exp 0", rd_hazard); end
      drain_en = 1'b1; BVALID = 1'b1; BRESP = 2'b00;
      tick();
      n_checks++; if (AWADDR !== 32'h0000_0100) begin n_fail++; $display("FAIL t2_drain_order got %h exp 00000100", AWADDR); end
      for (int i = 0; i < 11; i++) tick();
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL t2_drained got %b exp 1", empty); end
      drain_en = 1'b0; BVALID = 1'b0;
   endtask

   task automatic test_merge();
      push(32'h0000_1000, 32'h11223344, 4'h1);
      push(32'h0000_1002, 32'hAABBCCDD, 4'h4);
      drain_en = 1'b1;
      tick();
      n_checks++; if (WSTRB !== 4'h5) begin n_fail++; $display("FAIL t3_wstrb got %h exp 5", WSTRB); end
      n_checks++; if (WDATA[7:0] !== 8'h44) begin n_fail++; $display("FAIL t3_byte0 got %h exp 44", WDATA[7:0]); end
      n_checks++; if (WDATA[23:16] !== 8'hBB) begin n_fail++; $display("FAIL t3_byte2 got %h exp bb", WDATA[23:16]); end
      n_checks++; if (AWADDR !== 32'h0000_1000) begin n_fail++; $display("FAIL t3_awaddr got %h exp 00001000", AWADDR); end
      BVALID = 1'b1;
      tick(); tick();
      BVALID = 1'b0; drain_en = 1'b0;
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL t3_single_entry got %b exp 1", empty); end
   endtask

   task automatic test_split_handshake();
      drain_en = 1'b1; AWREADY = 1'b1; WREADY = 1'b0;
      push(32'h0000_2000, 32'hCAFEF00D, 4'hF);
      tick();
      n_checks++; if ({AWVALID, WVALID, BREADY} !== 3'b110) begin n_fail++; $display("FAIL t4_send got %b exp 110", {AWVALID, WVALID, BREADY}); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if ({AWVALID, WVALID, BREADY} !== 3'b010) begin n_fail++; $display("FAIL t4_wait%0d got %b exp 010", i, {AWVALID, WVALID, BREADY}); end
      end
      WREADY = 1'b1;
      tick();
      n_checks++; if ({AWVALID, WVALID, BREADY} !== 3'b001) begin n_fail++; $display("FAIL t4_resp got %b exp 001", {AWVALID, WVALID, BREADY}); end
      BVALID = 1'b1;
      tick();
      BVALID = 1'b0; drain_en = 1'b0;
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL t4_empty got %b exp 1", empty); end
   endtask

   task automatic test_bresp_err();
      push(32'h0000_3000, 32'h0000_000A, 4'hF);
      push(32'h0000_3004, 32'h0000_000B, 4'hF);
      n_checks++; if (bresp_err !== 1'b0) begin n_fail++; $display("FAIL t5_err_clear got %b exp 0", bresp_err); end
      drain_en = 1'b1; BVALID = 1'b1; BRESP = 2'b10;
      tick(); tick(); tick();
      BRESP = 2'b00;
      n_checks++; if (bresp_err !== 1'b1) begin n_fail++; $display("FAIL t5_err_set got %b exp 1", bresp_err); end
      tick();
      n_checks++; if (AWADDR !== 32'h0000_3004) begin n_fail++; $display("FAIL t5_next_addr got %h exp 00003004", AWADDR); end
      n_checks++; if (WDATA !== 32'h0000_000B) begin n_fail++; $display("FAIL t5_next_data got %h exp 0000000b", WDATA); end
      tick(); tick();
      BVALID = 1'b0; drain_en = 1'b0;
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL t5_empty got %b exp 1", empty); end
      n_checks++; if (bresp_err !== 1'b1) begin n_fail++; $display("FAIL t5_err_sticky got %b exp 1", bresp_err); end
   endtask

   task automatic test_back_to_back();
      push(32'h0000_4000, 32'h40, 4'hF);
      push(32'h0000_4004, 32'h44, 4'hF);
      push(32'h0000_4008, 32'h48, 4'hF);
      push(32'h0000_400C, 32'h4C, 4'hF);
      drain_en = 1'b1; BVALID = 1'b1;
      tick(); tick();
      wr_valid = 1'b1; wr_addr = 32'h0000_4010; wr_data = 32'h50; wr_strb = 4'hF; #1;
      n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL t6_pop_cycle_ready got %b exp 0", wr_ready); end
      tick();
      drain_en = 1'b0; BVALID = 1'b0; #1;
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL t6_after_pop_full got %b exp 0", full); end
      n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL t6_after_pop_ready got %b exp 1", wr_ready); end
      tick();
      wr_valid = 1'b0;
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL t6_refill_full got %b exp 1", full); end
      AWREADY = 1'b0; WREADY = 1'b0; drain_en = 1'b1;
      tick();
      n_checks++; if (AWVALID !== 1'b1) begin n_fail++; $display("FAIL t6_send got %b exp 1", AWVALID); end
      rst = 1'b1; #1;
      n_checks++; if ({AWVALID, WVALID} !== 2'b00) begin n_fail++; $display("FAIL t6_rst_valids got %b exp 00", {AWVALID, WVALID}); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL t6_rst_empty got %b exp 1", empty); end
      n_checks++; if (bresp_err !== 1'b0) begin n_fail++; $display("FAIL t6_rst_err got %b exp 0", bresp_err); end
      tick();
      rst = 1'b0; drain_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_full_hazard();
      test_merge();
      test_split_handshake();
      test_bresp_err();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
